// File: rtl/pipeline_flow_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_flow_ctrl
//
// Purpose:
//   Flow controller for a classic five-stage in-order pipeline. It arbitrates
//   between three stall/flush sources, in this order of priority:
//     1. memory freeze   (mem_req & ~mem_ready): freeze every stage
//     2. hazard stall    (hz_stall): hold PC and IF/ID, bubble ID/EX
//     3. taken branch    (pc_src): flush IF/ID and redirect the PC
//   All control outputs are combinational from the current state, the inputs
//   and RSTn. The state register only records the condition that applied in
//   the previous cycle. That record lets FLUSH ignore pc_src for one cycle,
//   and it shows where a memory wait is in progress.
//
//   The block also runs a bounded memory-wait watchdog. err_timeout is a
//   sticky flag. The block also keeps a saturating count of stalled cycles,
//   meaning cycles in which the PC is not written.
//
// Parameters:
//   WAIT_W   - width of the internal memory-wait cycle counter
//   MAX_WAIT - consecutive MEM_WAIT cycles (with freeze) before timeout
//   CNT_W    - width of the stall-cycle performance counter
//
// Ports:
//   CLK          in   rising-edge clock
//   RSTn         in   asynchronous active-low reset
//   hz_stall     in   load-use / branch-operand hazard request
//   pc_src       in   branch or jump taken (resolved in ID)
//   mem_req      in   data-memory access present in MEM
//   mem_ready    in   data memory completed the current access
//   pc_we        out  PC load enable
//   ifid_we      out  IF/ID load enable
//   ifid_flush   out  load NOP into IF/ID
//   idex_bubble  out  load NOP into ID/EX
//   pipe_hold    out  hold ID/EX, EX/MEM, MEM/WB and suppress WB write
//   state        out  RUN=00, LU_STALL=01, FLUSH=10, MEM_WAIT=11
//   stall_cnt    out  saturating count of cycles with pc_we=0
//   err_timeout  out  sticky memory-wait timeout flag
// ---------------------------------------------------------------------------
module pipeline_flow_ctrl #(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 12,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             hz_stall,
    input  logic             pc_src,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err_timeout
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_FLUSH    = 2'b10,
        ST_MEM_WAIT = 2'b11
    } state_t;

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE_C = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO_C = WAIT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_MAX_C  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE_C  = CNT_W'(1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic              err_r;
    logic              err_nxt_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_nxt_s;
    logic              freeze_s;
    logic              in_wait_s;

    logic              pc_we_s;
    logic              ifid_we_s;
    logic              ifid_flush_s;
    logic              idex_bubble_s;
    logic              pipe_hold_s;

    // Freeze is evaluated in every state. A ready without a request is meaningless.
    assign freeze_s  = mem_req & ~mem_ready;
    assign in_wait_s = (state_r == ST_MEM_WAIT);

    // Priority arbitration: next state and combinational pipeline controls.
    always_comb begin
        state_nxt_s   = ST_RUN;
        pc_we_s       = 1'b1;
        ifid_we_s     = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        pipe_hold_s   = 1'b0;
        if (!RSTn) begin
            // While in reset, keep the PC still and push NOPs into both front stages.
            state_nxt_s   = ST_RUN;
            pc_we_s       = 1'b0;
            ifid_we_s     = 1'b0;
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
            pipe_hold_s   = 1'b0;
        end else if (freeze_s) begin
            state_nxt_s   = ST_MEM_WAIT;
            pc_we_s       = 1'b0;
            ifid_we_s     = 1'b0;
            ifid_flush_s  = 1'b0;
            idex_bubble_s = 1'b0;
            pipe_hold_s   = 1'b1;
        end else if (hz_stall) begin
            state_nxt_s   = ST_LU_STALL;
            pc_we_s       = 1'b0;
            ifid_we_s     = 1'b0;
            ifid_flush_s  = 1'b0;
            idex_bubble_s = 1'b1;
            pipe_hold_s   = 1'b0;
        end else if (pc_src && (state_r != ST_FLUSH)) begin
            // The cycle after a flush still sees the same resolved branch in ID.
            // For that reason pc_src is ignored for one cycle while in FLUSH.
            state_nxt_s   = ST_FLUSH;
            pc_we_s       = 1'b1;
            ifid_we_s     = 1'b1;
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b0;
            pipe_hold_s   = 1'b0;
        end else begin
            state_nxt_s   = ST_RUN;
            pc_we_s       = 1'b1;
            ifid_we_s     = 1'b1;
            ifid_flush_s  = 1'b0;
            idex_bubble_s = 1'b0;
            pipe_hold_s   = 1'b0;
        end
    end

    // Memory-wait watchdog: count frozen cycles spent in MEM_WAIT, clamp at the limit.
    always_comb begin
        wait_cnt_nxt_s = wait_cnt_r;
        err_nxt_s      = err_r;
        if (!freeze_s) begin
            wait_cnt_nxt_s = WAIT_ZERO_C;
        end else if (in_wait_s) begin
            if (err_r || (wait_cnt_r >= MAX_WAIT_C)) begin
                wait_cnt_nxt_s = MAX_WAIT_C;
            end else begin
                wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE_C;
            end
        end else begin
            // The first frozen cycle is still in its old state, so it is not a wait cycle.
            wait_cnt_nxt_s = wait_cnt_r;
        end
        // Once the limit is reached, the flag stays set until reset.
        if (freeze_s && in_wait_s && (wait_cnt_nxt_s == MAX_WAIT_C)) begin
            err_nxt_s = 1'b1;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Stall performance counter: count cycles with pc_we low, saturating at all-ones.
    always_comb begin
        stall_cnt_nxt_s = stall_cnt_r;
        if (!pc_we_s && (stall_cnt_r != CNT_MAX_C)) begin
            stall_cnt_nxt_s = stall_cnt_r + CNT_ONE_C;
        end else begin
            stall_cnt_nxt_s = stall_cnt_r;
        end
    end

    // State, watchdog and counter registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r     <= ST_RUN;
            wait_cnt_r  <= WAIT_ZERO_C;
            err_r       <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            wait_cnt_r  <= wait_cnt_nxt_s;
            err_r       <= err_nxt_s;
            stall_cnt_r <= stall_cnt_nxt_s;
        end
    end

    assign pc_we       = pc_we_s;
    assign ifid_we     = ifid_we_s;
    assign ifid_flush  = ifid_flush_s;
    assign idex_bubble = idex_bubble_s;
    assign pipe_hold   = pipe_hold_s;
    assign state       = state_r;
    assign stall_cnt   = stall_cnt_r;
    assign err_timeout = err_r;

endmodule

// File: doc/pipeline_flow_ctrl.md
PIPELINE_FLOW_CTRL -- requirements
Module: pipeline_flow_ctrl

Interface
REQ-001 Parameter WAIT_W, default 4: width of the memory-wait cycle counter.
REQ-002 Parameter MAX_WAIT, default 12: maximum number of consecutive memory-wait cycles before timeout.
REQ-003 Parameter CNT_W, default 16: width of the stall-cycle performance counter.
REQ-004 CLK  in  1  the single clock; all state changes on the rising edge.
REQ-005 RSTn  in  1  asynchronous, active-low reset.
REQ-006 hz_stall  in  1  load-use or branch-operand hazard from the hazard detector; same-cycle request.
REQ-007 pc_src  in  1  branch or jump taken, resolved in ID.
REQ-008 mem_req  in  1  a data-memory access is present in MEM.
REQ-009 mem_ready  in  1  data memory has completed the current access.
REQ-010 pc_we  out  1  PC register load enable.
REQ-011 ifid_we  out  1  IF/ID register load enable.
REQ-012 ifid_flush  out  1  load a NOP into IF/ID.
REQ-013 idex_bubble  out  1  load a NOP (all control bits 0) into ID/EX.
REQ-014 pipe_hold  out  1  hold ID/EX, EX/MEM and MEM/WB; suppress WB register write.
REQ-015 state  out  2  current state: RUN=00, LU_STALL=01, FLUSH=10, MEM_WAIT=11.
REQ-016 stall_cnt  out  CNT_W  saturating count of cycles with pc_we=0 while RSTn=1.
REQ-017 err_timeout  out  1  sticky memory-wait timeout flag.

Function
REQ-018 The state register SHALL update on the CLK rising edge; all control outputs SHALL be combinational from state, inputs and RSTn.
REQ-019 The controller SHALL define freeze = mem_req & ~mem_ready, evaluated in every state.
REQ-020 Priority SHALL be freeze > hz_stall > pc_src.
REQ-021 When freeze=1, the controller SHALL drive pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0 and pipe_hold=1; next state SHALL be MEM_WAIT.
REQ-022 When freeze=0 and hz_stall=1, the controller SHALL drive pc_we=0, ifid_we=0, idex_bubble=1 and pipe_hold=0; next state SHALL be LU_STALL.
REQ-023 When freeze=0, hz_stall=0, pc_src=1 and state is not FLUSH, the controller SHALL drive pc_we=1, ifid_we=1, ifid_flush=1 and idex_bubble=0; next state SHALL be FLUSH.
REQ-024 In state FLUSH, pc_src SHALL be ignored for exactly one cycle; the next state SHALL be RUN unless freeze or hz_stall applies.
REQ-025 When no condition applies, the controller SHALL drive pc_we=1, ifid_we=1 and all other controls 0; next state SHALL be RUN.
REQ-026 LU_STALL SHALL persist for as long as hz_stall stays 1; when hz_stall drops, pc_src SHALL be evaluated in that same cycle.
REQ-027 wait_cnt (internal, WAIT_W bits) SHALL increment on every cycle spent in MEM_WAIT with freeze=1, and SHALL clear on any cycle with freeze=0.
REQ-028 When wait_cnt reaches MAX_WAIT with freeze still 1, err_timeout SHALL set to 1, and SHALL remain 1 until reset.
REQ-029 After err_timeout sets, wait_cnt SHALL hold at MAX_WAIT and the state SHALL remain MEM_WAIT until mem_ready=1.
REQ-030 When mem_ready=1 in MEM_WAIT, the controller SHALL release the hold in that same cycle and apply REQ-022..025 combinationally.
REQ-031 stall_cnt SHALL increment on every cycle with pc_we=0, SHALL saturate at all-ones, and SHALL never wrap.
REQ-032 mem_ready=1 with mem_req=0 SHALL have no effect.

Reset
REQ-033 While RSTn=0, the controller SHALL force: state=RUN, wait_cnt=0, stall_cnt=0, err_timeout=0, pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1 and pipe_hold=0.
REQ-034 Assertion of RSTn mid-stall or mid-wait SHALL abort the sequence immediately and asynchronously.
REQ-035 The first edge after RSTn rises SHALL evaluate from state RUN.

Verification
REQ-036 Scenario 1 (load-use): hz_stall=1 for 1 cycle -> pc_we=0, ifid_we=0, idex_bubble=1 that cycle; state=01 next cycle; RUN outputs after; stall_cnt=1.
REQ-037 Scenario 2 (branch taken): pc_src=1 for 2 cycles -> ifid_flush=1 in cycle 1 only; state=10 then 00; no second flush.
REQ-038 Scenario 3 (simultaneous events): hz_stall=1 and pc_src=1 together -> stall wins, no flush; after hz_stall=0 with pc_src=1 -> flush in that cycle.
REQ-039 Scenario 4 (memory wait): mem_req=1, mem_ready=0 for 3 cycles then 1 -> pipe_hold=1 for 3 cycles; state=11; release on the ready cycle; stall_cnt=3; err_timeout=0.
REQ-040 Scenario 5 (timeout): mem_ready=0 for 14 cycles with MAX_WAIT=12 -> err_timeout=1 after the 12th wait cycle; stays 1 after mem_ready until RSTn=0.
REQ-041 Scenario 6 (reset mid-wait and saturation): RSTn=0 in MEM_WAIT -> immediate state=00 and reset outputs; with CNT_W=4, 20 stall cycles -> stall_cnt=15.
